// File: rtl/dpram_arb_pkg.sv
// Shared constants and helpers for the dual-port RAM arbiter.
//   RAM_AW / RAM_DW / RAM_DEPTH : geometry of the dpram_1024x8 macro
//   MAX_NREQ                    : largest supported requester count
//   rr_next(idx, n)             : (idx + 1) mod n without a divider
package dpram_arb_pkg;

    localparam int RAM_AW    = 10;
    localparam int RAM_DW    = 8;
    localparam int RAM_DEPTH = 1024;
    localparam int MAX_NREQ  = 8;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dpram_arb_rr_pick.sv
// Round-robin scanner: starting at ptr_i and wrapping modulo NREQ, returns
// the first and second asserted bits of valid_i.
//   valid_i        : per-requester request valid
//   ptr_i          : scan start index
//   first_idx_o    : index of first valid requester (0 when none)
//   first_found_o  : a first valid requester exists
//   second_idx_o   : index of next valid requester after the first
//   second_found_o : a second valid requester exists
module dpram_arb_rr_pick
    import dpram_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   first_idx_o,
    output logic            first_found_o,
    output logic [IW-1:0]   second_idx_o,
    output logic            second_found_o
);

    int unsigned scan_j;

    always_comb begin
        first_idx_o    = '0;
        first_found_o  = 1'b0;
        second_idx_o   = '0;
        second_found_o = 1'b0;
        scan_j         = 32'(ptr_i);
        for (int k = 0; k < NREQ; k++) begin
            if (valid_i[scan_j[IW-1:0]]) begin
                if (!first_found_o) begin
                    first_found_o = 1'b1;
                    first_idx_o   = scan_j[IW-1:0];
                end else if (!second_found_o) begin
                    second_found_o = 1'b1;
                    second_idx_o   = scan_j[IW-1:0];
                end
            end
            scan_j = rr_next(scan_j, NREQ);
        end
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Shares both ports of a 1024x8 dual-port synchronous RAM between NREQ
// valid/ready requesters. Up to two requests are granted per cycle in
// round-robin order: the first to RAM port 1, the second to RAM port 2.
// Read data returns to the requester exactly one cycle after its grant.
//   clk, rst_n            : clock (also the RAM clock), async active-low reset
//   req_valid/ready/we    : per-requester handshake and direction
//   req_addr/req_wdata    : flattened, requester i at [i*W +: W]
//   rsp_valid/rsp_data    : per-requester read response (data 0 when idle)
//   wen1/addr1/d_in1      : RAM port 1 controls (combinational)
//   wen2/addr2/d_in2      : RAM port 2 controls (combinational)
//   d_out1/d_out2         : RAM read data, valid the cycle after the read
// Optional build macro DPRAM_ARB_STATS_EN adds stat_clr, stat_conflicts
// and stat_grants (saturating 16-bit counters).
module dpram_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = RAM_AW,
    parameter int DW   = RAM_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [NREQ*DW-1:0] rsp_data,
    output logic              wen1,
    output logic [AW-1:0]     addr1,
    output logic [DW-1:0]     d_in1,
    output logic              wen2,
    output logic [AW-1:0]     addr2,
    output logic [DW-1:0]     d_in2,
    input  logic [DW-1:0]     d_out1,
    input  logic [DW-1:0]     d_out2
`ifdef DPRAM_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_conflicts,
    output logic [15:0]       stat_grants
`endif
);

    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
        $error("dpram_arbiter: NREQ must be in 2..%0d", MAX_NREQ);
    end
    if (AW != RAM_AW || DW != RAM_DW) begin : g_bad_geom
        $error("dpram_arbiter: AW/DW must match the RAM macro");
    end

    logic [AW-1:0] addr_arr  [NREQ];
    logic [DW-1:0] wdata_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*AW +: AW];
        assign wdata_arr[g] = req_wdata[g*DW +: DW];
    end

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic          pend_v1_q, pend_v1_d, pend_v2_q, pend_v2_d;
    logic [IW-1:0] pend_id1_q, pend_id1_d, pend_id2_q, pend_id2_d;

    logic [IW-1:0] idx_a, idx_b;
    logic          found_a, found_b;
    logic          collide;
    logic          gnt_a, gnt_b;

    dpram_arb_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .valid_i        (req_valid),
        .ptr_i          (rr_ptr_q),
        .first_idx_o    (idx_a),
        .first_found_o  (found_a),
        .second_idx_o   (idx_b),
        .second_found_o (found_b)
    );

    // Same-address pairs may only be granted together when both are reads;
    // otherwise port ordering within one RAM cycle would be undefined.
    assign collide = found_a && found_b && (addr_arr[idx_a] == addr_arr[idx_b])
                     && (req_we[idx_a] || req_we[idx_b]);

    // Gating with rst_n keeps the RAM quiet while reset is held.
    assign gnt_a = rst_n && found_a;
    assign gnt_b = rst_n && found_b && !collide;

    always_comb begin
        req_ready = '0;
        if (gnt_a) req_ready[idx_a] = 1'b1;
        if (gnt_b) req_ready[idx_b] = 1'b1;
    end

    always_comb begin
        wen1  = gnt_a && req_we[idx_a];
        addr1 = gnt_a ? addr_arr[idx_a] : '0;
        d_in1 = wen1 ? wdata_arr[idx_a] : '0;
        wen2  = gnt_b && req_we[idx_b];
        addr2 = gnt_b ? addr_arr[idx_b] : '0;
        d_in2 = wen2 ? wdata_arr[idx_b] : '0;
    end

    always_comb begin
        pend_v1_d  = gnt_a && !req_we[idx_a];
        pend_id1_d = idx_a;
        pend_v2_d  = gnt_b && !req_we[idx_b];
        pend_id2_d = idx_b;
        rr_ptr_d   = rr_ptr_q;
        if (gnt_b) begin
            rr_ptr_d = IW'(rr_next(32'(idx_b), NREQ));
        end else if (gnt_a) begin
            rr_ptr_d = IW'(rr_next(32'(idx_a), NREQ));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            pend_v1_q  <= 1'b0;
            pend_id1_q <= '0;
            pend_v2_q  <= 1'b0;
            pend_id2_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            pend_v1_q  <= pend_v1_d;
            pend_id1_q <= pend_id1_d;
            pend_v2_q  <= pend_v2_d;
            pend_id2_q <= pend_id2_d;
        end
    end

    // A requester never holds both ports, so the two lanes never overlap.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pend_v1_q && pend_id1_q == IW'(i)) begin
                rsp_valid[i]         = 1'b1;
                rsp_data[i*DW +: DW] = d_out1;
            end else if (pend_v2_q && pend_id2_q == IW'(i)) begin
                rsp_valid[i]         = 1'b1;
                rsp_data[i*DW +: DW] = d_out2;
            end
        end
    end

`ifdef DPRAM_ARB_STATS_EN
    logic [15:0] stat_conflicts_q, stat_conflicts_d;
    logic [15:0] stat_grants_q, stat_grants_d;
    logic [16:0] grant_sum;

    always_comb begin
        stat_conflicts_d = stat_conflicts_q;
        stat_grants_d    = stat_grants_q;
        grant_sum        = {1'b0, stat_grants_q} + 17'(gnt_a) + 17'(gnt_b);
        if (stat_clr) begin
            stat_conflicts_d = '0;
            stat_grants_d    = '0;
        end else begin
            if (rst_n && collide && stat_conflicts_q != 16'hFFFF) begin
                stat_conflicts_d = stat_conflicts_q + 16'd1;
            end
            stat_grants_d = grant_sum[16] ? 16'hFFFF : grant_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_conflicts_q <= '0;
            stat_grants_q    <= '0;
        end else begin
            stat_conflicts_q <= stat_conflicts_d;
            stat_grants_q    <= stat_grants_d;
        end
    end

    assign stat_conflicts = stat_conflicts_q;
    assign stat_grants    = stat_grants_q;
`endif

endmodule

// File: tb/tb_dpram_arbiter.sv
module tb_dpram_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 10;
    localparam int DW   = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NREQ-1:0]   req_valid, req_ready, req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ*DW-1:0] rsp_data;
    logic              wen1, wen2;
    logic [AW-1:0]     addr1, addr2;
    logic [DW-1:0]     d_in1, d_in2, d_out1, d_out2;
`ifdef DPRAM_ARB_STATS_EN
    logic              stat_clr;
    logic [15:0]       stat_conflicts, stat_grants;
`endif

    dpram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .wen1      (wen1),
        .addr1     (addr1),
        .d_in1     (d_in1),
        .wen2      (wen2),
        .addr2     (addr2),
        .d_in2     (d_in2),
        .d_out1    (d_out1),
        .d_out2    (d_out2)
`ifdef DPRAM_ARB_STATS_EN
        ,
        .stat_clr       (stat_clr),
        .stat_conflicts (stat_conflicts),
        .stat_grants    (stat_grants)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural dpram_1024x8: synchronous, registered read data.
    logic [DW-1:0] ram [1024];
    always @(posedge clk) begin
        if (wen1) ram[addr1] <= d_in1;
        if (wen2) ram[addr2] <= d_in2;
        d_out1 <= ram[addr1];
        d_out2 <= ram[addr2];
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int              m_ptr;
    logic [DW-1:0]   m_mem [1024];
    logic [NREQ-1:0] cur_v;
    logic [DW-1:0]   cur_d [NREQ];
    int              e_a, e_b;
    logic [NREQ-1:0] exp_ready;
    logic            exp_wen1, exp_wen2;
    logic [AW-1:0]   exp_addr1, exp_addr2;
    logic [DW-1:0]   exp_din1, exp_din2;

    function automatic logic [AW-1:0] addr_of(int i);
        return req_addr[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] wdata_of(int i);
        return req_wdata[i*DW +: DW];
    endfunction

    function automatic logic [NREQ*DW-1:0] exp_rsp_flat();
        logic [NREQ*DW-1:0] f;
        f = '0;
        for (int i = 0; i < NREQ; i++) if (cur_v[i]) f[i*DW +: DW] = cur_d[i];
        return f;
    endfunction

    task automatic set_req(int i, bit v, bit we, int a, int d);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a[AW-1:0];
        req_wdata[i*DW +: DW] = d[DW-1:0];
    endtask

    task automatic model_reset();
        m_ptr = 0;
        cur_v = '0;
        for (int i = 0; i < NREQ; i++) cur_d[i] = '0;
    endtask

    // Grant rule: scan from the pointer, first two valid requesters; the
    // second is refused if it shares an address with the first and either writes.
    task automatic model_eval();
        int first, second;
        bit col;
        first = -1;
        second = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        col = (first >= 0) && (second >= 0) && (addr_of(first) == addr_of(second))
              && (req_we[first] || req_we[second]);
        e_a = rst_n ? first : -1;
        e_b = (rst_n && !col) ? second : -1;
        exp_ready = '0;
        if (e_a >= 0) exp_ready[e_a] = 1'b1;
        if (e_b >= 0) exp_ready[e_b] = 1'b1;
        exp_wen1  = (e_a >= 0) && req_we[e_a];
        exp_addr1 = (e_a >= 0) ? addr_of(e_a) : '0;
        exp_din1  = exp_wen1 ? wdata_of(e_a) : '0;
        exp_wen2  = (e_b >= 0) && req_we[e_b];
        exp_addr2 = (e_b >= 0) ? addr_of(e_b) : '0;
        exp_din2  = exp_wen2 ? wdata_of(e_b) : '0;
    endtask

    task automatic model_commit();
        logic [NREQ-1:0] nv;
        logic [DW-1:0]   nd [NREQ];
        int last;
        nv = '0;
        for (int i = 0; i < NREQ; i++) nd[i] = '0;
        if (e_a >= 0 && !req_we[e_a]) begin nv[e_a] = 1'b1; nd[e_a] = m_mem[addr_of(e_a)]; end
        if (e_b >= 0 && !req_we[e_b]) begin nv[e_b] = 1'b1; nd[e_b] = m_mem[addr_of(e_b)]; end
        if (e_a >= 0 && req_we[e_a]) m_mem[addr_of(e_a)] = wdata_of(e_a);
        if (e_b >= 0 && req_we[e_b]) m_mem[addr_of(e_b)] = wdata_of(e_b);
        last = (e_b >= 0) ? e_b : e_a;
        if (last >= 0) m_ptr = (last + 1) % NREQ;
        cur_v = nv;
        cur_d = nd;
    endtask

    task automatic tick();
        model_eval();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        req_valid = '1;
        req_we = '1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 1, 16 * i, 8'h11 * i);
        model_reset();
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== '0) begin n_bad++; $display("FAIL rst_ready got %b exp 0000", req_ready); end
            n_cmp++;
            if (wen1 !== 1'b0 || wen2 !== 1'b0) begin n_bad++; $display("FAIL rst_wen got %b%b exp 00", wen1, wen2); end
            n_cmp++;
            if (rsp_valid !== '0) begin n_bad++; $display("FAIL rst_rsp got %b exp 0000", rsp_valid); end
        end
        req_valid = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_eval();
        @(negedge clk);
        n_cmp++;
        if (req_ready !== '0 || addr1 !== '0 || d_in1 !== '0 || addr2 !== '0)
            begin n_bad++; $display("FAIL idle_ports ready %b addr1 %h d_in1 %h addr2 %h exp zeros", req_ready, addr1, d_in1, addr2); end
`ifdef DPRAM_ARB_STATS_EN
        n_cmp++;
        if (stat_conflicts !== 16'd0 || stat_grants !== 16'd0)
            begin n_bad++; $display("FAIL rst_stats got %0d/%0d exp 0/0", stat_conflicts, stat_grants); end
`endif
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        int wen1_cnt;
        wen1_cnt = 0;
        do_reset();
        set_req(0, 1, 1, 10'h3FF, 8'hA5);
        model_eval();
        @(negedge clk);
        if (wen1 === 1'b1) wen1_cnt++;
        n_cmp++;
        if (req_ready !== 4'b0001 || addr1 !== 10'h3FF || d_in1 !== 8'hA5 || wen2 !== 1'b0)
            begin n_bad++; $display("FAIL wr_grant ready %b addr1 %h d_in1 %h wen2 %b exp 0001 3ff a5 0", req_ready, addr1, d_in1, wen2); end
        model_commit();
        @(posedge clk);
        #1;
        req_valid = '0;
        set_req(1, 1, 0, 10'h3FF, 0);
        model_eval();
        @(negedge clk);
        if (wen1 === 1'b1) wen1_cnt++;
        n_cmp++;
        if (req_ready !== 4'b0010 || addr1 !== 10'h3FF || rsp_valid !== '0)
            begin n_bad++; $display("FAIL rd_grant ready %b addr1 %h rsp %b exp 0010 3ff 0000", req_ready, addr1, rsp_valid); end
        model_commit();
        @(posedge clk);
        #1;
        req_valid = '0;
        model_eval();
        @(negedge clk);
        if (wen1 === 1'b1) wen1_cnt++;
        n_cmp++;
        if (rsp_valid !== 4'b0010 || rsp_data[15:8] !== 8'hA5)
            begin n_bad++; $display("FAIL rd_rsp valid %b data %h exp 0010 a5", rsp_valid, rsp_data[15:8]); end
        n_cmp++;
        if (wen1_cnt != 1) begin n_bad++; $display("FAIL wen1_pulses got %0d exp 1", wen1_cnt); end
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic test_rr_reads();
        int rsp_cnt [NREQ];
        logic [NREQ-1:0] pat;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin rsp_cnt[i] = 0; set_req(i, 1, 0, 10'h100 + 16 * i, 0); end
        for (int c = 0; c < 9; c++) begin
            if (c == 8) req_valid = '0;
            model_eval();
            @(negedge clk);
            pat = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            if (c < 8) begin
                n_cmp++;
                if (req_ready !== pat || exp_ready !== pat)
                    begin n_bad++; $display("FAIL rr_ready cyc%0d got %b exp %b", c, req_ready, pat); end
            end
            n_cmp++;
            if (rsp_valid !== cur_v || rsp_data !== exp_rsp_flat())
                begin n_bad++; $display("FAIL rr_rsp cyc%0d valid %b data %h exp %b %h", c, rsp_valid, rsp_data, cur_v, exp_rsp_flat()); end
            for (int i = 0; i < NREQ; i++) if (rsp_valid[i] === 1'b1) rsp_cnt[i]++;
            model_commit();
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) if (exp_ready[i]) set_req(i, req_valid[i], 0, 10'h100 + 16 * i + c + 1, 0);
        end
        for (int i = 0; i < NREQ; i++) begin
            n_cmp++;
            if (rsp_cnt[i] != 4) begin n_bad++; $display("FAIL rr_count req%0d got %0d exp 4", i, rsp_cnt[i]); end
        end
    endtask

    task automatic test_collision();
        do_reset();
        set_req(0, 1, 1, 10'h010, 8'h3C);
        set_req(2, 1, 0, 10'h010, 0);
        model_eval();
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0001 || wen2 !== 1'b0)
            begin n_bad++; $display("FAIL coll_first ready %b wen2 %b exp 0001 0", req_ready, wen2); end
        model_commit();
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        model_eval();
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0100 || addr1 !== 10'h010 || wen1 !== 1'b0)
            begin n_bad++; $display("FAIL coll_retry ready %b addr1 %h wen1 %b exp 0100 010 0", req_ready, addr1, wen1); end
        model_commit();
        @(posedge clk);
        #1;
        req_valid = '0;
        model_eval();
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 4'b0100 || rsp_data[23:16] !== 8'h3C)
            begin n_bad++; $display("FAIL coll_data valid %b data %h exp 0100 3c", rsp_valid, rsp_data[23:16]); end
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic test_dual_read();
        do_reset();
        set_req(0, 1, 1, 10'h200, 8'h5A);
        tick();
        req_valid = '0;
        set_req(1, 1, 0, 10'h200, 0);
        set_req(3, 1, 0, 10'h200, 0);
        model_eval();
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b1010 || addr1 !== 10'h200 || addr2 !== 10'h200 || wen1 !== 1'b0 || wen2 !== 1'b0)
            begin n_bad++; $display("FAIL dual_grant ready %b addr %h/%h wen %b%b exp 1010 200/200 00", req_ready, addr1, addr2, wen1, wen2); end
        model_commit();
        @(posedge clk);
        #1;
        req_valid = '0;
        model_eval();
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 4'b1010 || rsp_data[15:8] !== 8'h5A || rsp_data[31:24] !== 8'h5A)
            begin n_bad++; $display("FAIL dual_rsp valid %b d1 %h d3 %h exp 1010 5a 5a", rsp_valid, rsp_data[15:8], rsp_data[31:24]); end
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int bad_before;
        bad_before = n_bad;
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || exp_ready[i])
                    set_req(i, ($urandom % 100) < 65, $urandom % 2, 10'h080 + ($urandom % 6),
                            $urandom % 256);
            end
            model_eval();
            @(negedge clk);
            n_cmp++;
            if (req_ready !== exp_ready)
                begin n_bad++; $display("FAIL rnd_ready cyc%0d got %b exp %b", c, req_ready, exp_ready); end
            n_cmp++;
            if (wen1 !== exp_wen1 || addr1 !== exp_addr1 || d_in1 !== exp_din1)
                begin n_bad++; $display("FAIL rnd_port1 cyc%0d got %b %h %h exp %b %h %h", c, wen1, addr1, d_in1, exp_wen1, exp_addr1, exp_din1); end
            n_cmp++;
            if (wen2 !== exp_wen2 || addr2 !== exp_addr2 || d_in2 !== exp_din2)
                begin n_bad++; $display("FAIL rnd_port2 cyc%0d got %b %h %h exp %b %h %h", c, wen2, addr2, d_in2, exp_wen2, exp_addr2, exp_din2); end
            n_cmp++;
            if (rsp_valid !== cur_v || rsp_data !== exp_rsp_flat())
                begin n_bad++; $display("FAIL rnd_rsp cyc%0d got %b %h exp %b %h", c, rsp_valid, rsp_data, cur_v, exp_rsp_flat()); end
            model_commit();
            @(posedge clk);
            #1;
            if (n_bad - bad_before > 10) break;
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_reset_inflight();
        do_reset();
        set_req(0, 1, 0, 10'h3FF, 0);
        model_eval();
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL inflight_ready got %b exp 0001", req_ready); end
        model_commit();
        #2;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 10'h300 + i, 0);
        #1;
        n_cmp++;
        if (rsp_valid !== '0) begin n_bad++; $display("FAIL inflight_drop got %b exp 0000", rsp_valid); end
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== '0 || req_ready !== '0 || wen1 !== 1'b0 || wen2 !== 1'b0)
                begin n_bad++; $display("FAIL inflight_hold rsp %b ready %b wen %b%b exp 0000 0000 00", rsp_valid, req_ready, wen1, wen2); end
        end
        #1;
        rst_n = 1'b1;
        #1;
        model_eval();
        n_cmp++;
        if (req_ready !== 4'b0011 || addr1 !== 10'h300 || addr2 !== 10'h301)
            begin n_bad++; $display("FAIL post_rst_grant ready %b addr %h/%h exp 0011 300/301", req_ready, addr1, addr2); end
        model_commit();
        @(posedge clk);
        #1;
        req_valid = '0;
        model_eval();
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 4'b0011 || rsp_data !== exp_rsp_flat())
            begin n_bad++; $display("FAIL post_rst_rsp got %b %h exp 0011 %h", rsp_valid, rsp_data, exp_rsp_flat()); end
        model_commit();
        @(posedge clk);
        #1;
    endtask

`ifdef DPRAM_ARB_STATS_EN
    task automatic test_stats();
        stat_clr = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req_valid = '0;
            set_req(0, 1, 1, 10'h040 + k, 8'h70 + k);
            set_req(1, 1, 0, 10'h040 + k, 0);
            tick();
            req_valid[0] = 1'b0;
            tick();
        end
        req_valid = '0;
        set_req(2, 1, 0, 10'h050, 0);
        set_req(3, 1, 0, 10'h051, 0);
        tick();
        tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (stat_conflicts !== 16'd3 || stat_grants !== 16'd10)
            begin n_bad++; $display("FAIL stats_count got %0d/%0d exp 3/10", stat_conflicts, stat_grants); end
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 10'h060 + i, 0);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (stat_conflicts !== 16'd0 || stat_grants !== 16'd0)
            begin n_bad++; $display("FAIL stats_clr got %0d/%0d exp 0/0", stat_conflicts, stat_grants); end
        @(posedge clk);
        #1;
        req_valid = '1;
        repeat (35000) tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (stat_grants !== 16'hFFFF || stat_conflicts !== 16'd0)
            begin n_bad++; $display("FAIL stats_sat got %h/%h exp ffff/0000", stat_grants, stat_conflicts); end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
`ifdef DPRAM_ARB_STATS_EN
        stat_clr  = 1'b0;
`endif
        for (int i = 0; i < 1024; i++) begin
            ram[i]   = 8'((i * 7 + 3) % 256);
            m_mem[i] = 8'((i * 7 + 3) % 256);
        end
        model_reset();
        e_a = -1;
        e_b = -1;
        exp_ready = '0;
        test_reset();
        test_write_read();
        test_rr_reads();
        test_collision();
        test_dual_read();
        test_random();
        test_reset_inflight();
`ifdef DPRAM_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
